// File: rtl/aes_ahb_slave.sv
// AHB-Lite register slave wrapping an AES core: zero-wait OKAY for legal word accesses,
// two-cycle ERROR (HREADYOUT low for one cycle) for non-word or misaligned ones.
module aes_ahb_slave #(
   parameter logic [31:0] ID_VALUE = 32'hAE50_0001
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         HSEL,
   input  logic [7:0]   HADDR,
   input  logic [1:0]   HTRANS,
   input  logic         HWRITE,
   input  logic [2:0]   HSIZE,
   input  logic [31:0]  HWDATA,
   input  logic         HREADY,
   output logic [31:0]  HRDATA,
   output logic         HREADYOUT,
   output logic         HRESP,
   output logic         aes_start,
   output logic [127:0] key_block,
   output logic [127:0] pt_block,
   input  logic [127:0] ct_block,
   input  logic         aes_busy,
   input  logic         aes_done,
   output logic         irq
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic [1:0]        state;
   logic              dp_vld;
   logic              cap_write;
   logic [5:0]        cap_word;
   logic [3:0][31:0]  key_q;
   logic [3:0][31:0]  pt_q;
   logic [3:0][31:0]  ct_q;
   logic              irq_en;
   logic              done;
   logic              werr;
   logic              start_pending;

   logic addr_ph, illegal, wr, busy;
   logic wr_key, wr_pt, wr_ctrl, wr_status;
   logic start_go, start_rej, kp_rej;
   logic unused;

   assign unused    = HTRANS[0];
   // No new address phase is accepted while the first ERROR cycle stalls the bus.
   assign addr_ph   = HSEL & HTRANS[1] & HREADY & (state != ST_ERR1);
   assign illegal   = (HSIZE != 3'b010) | (HADDR[1:0] != 2'b00);
   assign wr        = dp_vld & cap_write;
   assign busy      = aes_busy | start_pending;

   assign wr_key    = wr & (cap_word[5:2] == 4'd0);
   assign wr_pt     = wr & (cap_word[5:2] == 4'd1);
   assign wr_ctrl   = wr & (cap_word == 6'd12);
   assign wr_status = wr & (cap_word == 6'd13);

   assign start_go  = wr_ctrl & HWDATA[0] & ~busy;
   assign start_rej = wr_ctrl & HWDATA[0] & busy;
   assign kp_rej    = (wr_key | wr_pt) & busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         dp_vld        <= 1'b0;
         cap_write     <= 1'b0;
         cap_word      <= '0;
         key_q         <= '0;
         pt_q          <= '0;
         ct_q          <= '0;
         irq_en        <= 1'b0;
         done          <= 1'b0;
         werr          <= 1'b0;
         start_pending <= 1'b0;
         aes_start     <= 1'b0;
      end else begin
         if (state == ST_ERR1)
            state <= ST_ERR2;
         else if (addr_ph & illegal)
            state <= ST_ERR1;
         else
            state <= ST_IDLE;

         dp_vld <= addr_ph & ~illegal;
         if (addr_ph & ~illegal) begin
            cap_word  <= HADDR[7:2];
            cap_write <= HWRITE;
         end

         if (wr_key & ~busy)
            key_q[cap_word[1:0]] <= HWDATA;
         if (wr_pt & ~busy)
            pt_q[cap_word[1:0]] <= HWDATA;
         if (aes_done)
            ct_q <= ct_block;
         if (wr_ctrl)
            irq_en <= HWDATA[1];

         aes_start <= start_go;

         // Pending bridges the gap between the start pulse and the core raising busy.
         if (start_go)
            start_pending <= 1'b1;
         else if (aes_busy | aes_done)
            start_pending <= 1'b0;

         if (aes_done)
            done <= 1'b1;
         else if (start_go | (wr_status & HWDATA[1]))
            done <= 1'b0;

         if (start_rej | kp_rej)
            werr <= 1'b1;
         else if (wr_status & HWDATA[2])
            werr <= 1'b0;
      end
   end

   always_comb begin
      HRDATA = '0;
      if (dp_vld & ~cap_write) begin
         case (cap_word[5:2])
            4'd0: HRDATA = key_q[cap_word[1:0]];
            4'd1: HRDATA = pt_q[cap_word[1:0]];
            4'd2: HRDATA = ct_q[cap_word[1:0]];
            4'd3: begin
               case (cap_word[1:0])
                  2'd0:    HRDATA = {30'd0, irq_en, 1'b0};
                  2'd1:    HRDATA = {29'd0, werr, done, busy};
                  2'd2:    HRDATA = ID_VALUE;
                  default: HRDATA = '0;
               endcase
            end
            default: HRDATA = '0;
         endcase
      end
   end

   assign HREADYOUT = (state != ST_ERR1);
   assign HRESP     = (state != ST_IDLE);
   assign key_block = key_q;
   assign pt_block  = pt_q;
   assign irq       = done & irq_en;

endmodule

// File: doc/aes_ahb_slave.md
AES_AHB_SLAVE -- requirements
Module: aes_ahb_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'hAE50_0001, constant returned by ID register.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  8  byte address
- HTRANS  in  2  transfer type; bit1=1 NONSEQ/SEQ
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- aes_start  out  1  1-cycle start pulse to AES block
- key_block  out  128  key, KEY0 = bits 31:0
- pt_block  out  128  plaintext, PT0 = bits 31:0
- ct_block  in  128  ciphertext from AES block
- aes_busy  in  1  AES block working
- aes_done  in  1  1-cycle completion pulse
- irq  out  1  level interrupt

Function
REQ-003 SHALL use register map (word offsets): 0x00-0x0C KEY0-3 RW; 0x10-0x1C PT0-3 RW; 0x20-0x2C CT0-3 RO; 0x30 CTRL (bit0 START W1-pulse, reads 0; bit1 IRQ_EN RW); 0x34 STATUS (bit0 BUSY RO = aes_busy|start_pending; bit1 DONE W1C; bit2 WERR W1C); 0x38 ID RO.
REQ-004 SHALL capture address phase (HADDR, HWRITE, HSIZE) when HSEL & HTRANS[1] & HREADY; no capture otherwise.
REQ-005 SHALL complete legal transfers with zero wait states: HREADYOUT=1, HRESP=0.
REQ-006 SHALL commit write data from HWRITE-captured phase using HWDATA in the following (data-phase) cycle.
REQ-007 SHALL drive HRDATA combinationally from the captured address during the data phase; reads of unmapped offsets, CTRL bit0 and undefined bits return 0 with OKAY.
REQ-008 SHALL treat HSIZE != 3'b010 or HADDR[1:0] != 0 as illegal: two-cycle ERROR (cycle 1 HREADYOUT=0 HRESP=1; cycle 2 HREADYOUT=1 HRESP=1), no register side-effect.
REQ-009 SHALL ignore writes to CT, STATUS bit0 and ID with OKAY.
REQ-010 SHALL ignore KEY/PT writes while BUSY and set WERR; response OKAY.
REQ-011 SHALL, on CTRL write with bit0=1 while not BUSY, assert aes_start for exactly one cycle in the cycle after the data phase, and clear DONE in that same cycle.
REQ-012 SHALL ignore START while BUSY and set WERR.
REQ-013 SHALL hold start_pending from data phase of START until aes_busy seen high or aes_done, so BUSY never shows a gap.
REQ-014 SHALL on aes_done latch ct_block into CT0-3 and set DONE in the same edge.
REQ-015 SHALL give set priority when aes_done and DONE W1C coincide (DONE remains 1).
REQ-016 SHALL drive irq = DONE & IRQ_EN, registered-free combinational from flops.
REQ-017 SHALL drive key_block/pt_block directly from KEY/PT flops, stable while BUSY.
REQ-018 SHALL ignore aes_done when no operation pending or busy? No -- SHALL always honour aes_done (latch CT, set DONE) regardless of local state.

Reset
REQ-019 SHALL on rst=1 at clock edge clear KEY, PT, CT, IRQ_EN, DONE, WERR, start_pending, captured phase; aes_start=0, HREADYOUT=1, HRESP=0, HRDATA=0, irq=0.
REQ-020 SHALL abort an in-progress ERROR response on rst; mid-operation rst does not reset the AES block (caller's responsibility).

Verification
REQ-021 Write KEY0-3=00010203..0C0D0E0F, PT0-3 likewise, read back -> identical values, OKAY, no wait states.
REQ-022 Write CTRL=0x3 -> aes_start high exactly 1 cycle after data phase; STATUS.BUSY=1 until aes_done; on aes_done with ct_block=128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> CT0=70B4C55A, DONE=1, irq=1.
REQ-023 Write KEY1 and START while aes_busy=1 -> KEY1 unchanged, no aes_start, STATUS=0x5.
REQ-024 Write STATUS=0x2 in same cycle as aes_done -> DONE reads 1; next W1C -> DONE=0, irq=0.
REQ-025 Byte write (HSIZE=0) to KEY0 and word read at 0x22 -> two-cycle ERROR each, KEY0 unchanged.
REQ-026 Assert rst mid-ERROR and after START -> all outputs at REQ-019 values next cycle; ID reads ID_VALUE.
